// File: rtl/category_score_scheduler.sv
// ---------------------------------------------------------------------------
// category_score_scheduler
// Time-multiplexed category scorer. One captured vector of CATEGORIES x
// BITS_PER_CATEGORY bits is walked category by category, CHUNK bits per
// cycle, through a single shared popcount unit. The running best category
// (ties resolved to the lower index) is presented on a valid/ready output.
//
// Ports
//   clk         in   clock, all state on rising edge
//   reset       in   asynchronous active-high reset
//   flush       in   synchronous abort, drops in-flight and held results
//   in_valid    in   categories vector valid
//   in_ready    out  block accepts a vector this cycle
//   categories  in   class c occupies bits [c*BITS_PER_CATEGORY +: BITS_PER_CATEGORY]
//   out_valid   out  result valid
//   out_ready   in   consumer takes result
//   out_index   out  winning category
//   out_score   out  popcount of winning category
//   busy        out  high while accumulating
// ---------------------------------------------------------------------------
module category_score_scheduler #(
    parameter int CATEGORIES        = 10,
    parameter int BITS_PER_CATEGORY = 800,
    parameter int CHUNK             = 32,
    localparam int SUM_W            = $clog2(BITS_PER_CATEGORY + 1),
    localparam int IDX_W            = (CATEGORIES > 1) ? $clog2(CATEGORIES) : 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    flush,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [CATEGORIES*BITS_PER_CATEGORY-1:0] categories,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [IDX_W-1:0]                        out_index,
    output logic [SUM_W-1:0]                        out_score,
    output logic                                    busy
);

    localparam int CHUNKS   = (BITS_PER_CATEGORY + CHUNK - 1) / CHUNK;
    localparam int CHK_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int CNT_W    = $clog2(CHUNK + 1);
    localparam int PAD_BITS = CHUNKS * CHUNK;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                                  r_state;
    state_t                                  w_next;
    logic [CATEGORIES*BITS_PER_CATEGORY-1:0] r_cats;
    logic [IDX_W-1:0]                        r_cat;
    logic [CHK_W-1:0]                        r_chunk;
    logic [SUM_W-1:0]                        r_acc;
    logic [SUM_W-1:0]                        r_best_score;
    logic [IDX_W-1:0]                        r_best_index;

    logic [BITS_PER_CATEGORY-1:0]            w_cat_bits;
    logic [PAD_BITS-1:0]                     w_padded;
    logic [CHUNK-1:0]                        w_slice;
    logic [CNT_W-1:0]                        w_pop;
    logic [SUM_W-1:0]                        w_total;
    logic                                    w_last_chunk;
    logic                                    w_last_cat;
    logic                                    w_better;
    logic                                    w_take;

    function automatic logic [CNT_W-1:0] popcount(input logic [CHUNK-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s = s + CNT_W'(v[i]);
        end
        return s;
    endfunction

    assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == ACCUM);
    assign out_index = r_best_index;
    assign out_score = r_best_score;
    assign w_take    = in_valid & in_ready;

    // Select the current chunk; the category is zero-extended so the last chunk pads with zeros.
    always_comb begin
        w_cat_bits   = r_cats[r_cat*BITS_PER_CATEGORY +: BITS_PER_CATEGORY];
        w_padded     = PAD_BITS'(w_cat_bits);
        w_slice      = w_padded[r_chunk*CHUNK +: CHUNK];
        w_pop        = popcount(w_slice);
        w_total      = r_acc + SUM_W'(w_pop);
        w_last_chunk = (r_chunk == CHK_W'(CHUNKS - 1));
        w_last_cat   = (r_cat == IDX_W'(CATEGORIES - 1));
        // Strict compare keeps the lower index on ties; category 0 always seeds the best.
        w_better     = (r_cat == '0) | (w_total > r_best_score);
    end

    // Next-state decode; flush overrides every transition.
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) w_next = ACCUM;
                    else          w_next = IDLE;
                end
                ACCUM: begin
                    if (w_last_chunk && w_last_cat) w_next = DONE;
                    else                            w_next = ACCUM;
                end
                DONE: begin
                    if (out_ready && in_valid) w_next = ACCUM;
                    else if (out_ready)        w_next = IDLE;
                    else                       w_next = DONE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Capture, chunk walk, accumulation and best-category tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cats       <= '0;
            r_cat        <= '0;
            r_chunk      <= '0;
            r_acc        <= '0;
            r_best_score <= '0;
            r_best_index <= '0;
        end else if (flush) begin
            r_cat        <= '0;
            r_chunk      <= '0;
            r_acc        <= '0;
            r_best_score <= '0;
            r_best_index <= '0;
        end else if (w_take) begin
            r_cats  <= categories;
            r_cat   <= '0;
            r_chunk <= '0;
            r_acc   <= '0;
        end else if (r_state == ACCUM) begin
            if (w_last_chunk) begin
                r_acc   <= '0;
                r_chunk <= '0;
                if (w_better) begin
                    r_best_score <= w_total;
                    r_best_index <= r_cat;
                end
                if (!w_last_cat) r_cat <= r_cat + IDX_W'(1);
            end else begin
                r_acc   <= w_total;
                r_chunk <= r_chunk + CHK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_category_score_scheduler.sv
module tb_category_score_scheduler;

    localparam int CATS = 10;
    localparam int BPC  = 800;
    localparam int BPC2 = 50;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [CATS*BPC-1:0] cats;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_index;
    logic [9:0]      out_score;
    logic            busy;

    logic            flush2;
    logic            in_valid2;
    logic            in_ready2;
    logic [CATS*BPC2-1:0] cats2;
    logic            out_valid2;
    logic            out_ready2;
    logic [3:0]      out_index2;
    logic [5:0]      out_score2;
    logic            busy2;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    category_score_scheduler #(.CATEGORIES(CATS), .BITS_PER_CATEGORY(BPC), .CHUNK(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .categories(cats), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_score(out_score), .busy(busy)
    );

    category_score_scheduler #(.CATEGORIES(CATS), .BITS_PER_CATEGORY(BPC2), .CHUNK(16)) dut2 (
        .clk(clk), .reset(reset), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
        .categories(cats2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_index(out_index2), .out_score(out_score2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Sets the lowest n bits of category c in the main vector.
    task automatic set_cat(input int c, input int cnt);
        for (int i = 0; i < BPC; i++) cats[c*BPC + i] = (i < cnt);
    endtask

    // Accepts the current vector on the next edge and counts cycles until out_valid.
    task automatic run_one(input int limit, output int cycles);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cats = '0;
        flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1; cats2 = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_index", int'(out_index), 0);
        chk("rst_out_score", int'(out_score), 0);
        chk("rst_busy", int'(busy), 0);

        // 1: category 7 all ones
        cats = '0;
        set_cat(7, 800);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_busy", int'(busy), 1);
        chk("t1_in_ready_accum", int'(in_ready), 0);
        repeat (249) tick();
        chk("t1_valid_e249", int'(out_valid), 0);
        tick();
        chk("t1_valid_e250", int'(out_valid), 1);
        chk("t1_index", int'(out_index), 7);
        chk("t1_score", int'(out_score), 800);
        chk("t1_busy_done", int'(busy), 0);
        chk("t1_in_ready_done", int'(in_ready), 0);
        out_ready = 1'b1;
        #1;
        chk("t1_in_ready_oready", int'(in_ready), 1);
        tick();
        out_ready = 1'b0;
        chk("t1_idle_valid", int'(out_valid), 0);
        chk("t1_idle_in_ready", int'(in_ready), 1);

        // 3: all zero
        cats = '0;
        run_one(300, n);
        chk("t3_latency", n, 250);
        chk("t3_index", int'(out_index), 0);
        chk("t3_score", int'(out_score), 0);
        release_result();

        // 2: tie between 2 and 5 at 400, others 100
        for (int c = 0; c < CATS; c++) set_cat(c, 100);
        set_cat(2, 400);
        set_cat(5, 400);
        run_one(300, n);
        chk("t2_latency", n, 250);
        chk("t2_index", int'(out_index), 2);
        chk("t2_score", int'(out_score), 400);

        // 4: hold output with new data pending, then back-to-back accept
        cats = '0;
        set_cat(3, 800);
        in_valid = 1'b1;
        repeat (10) tick();
        chk("t4_hold_valid", int'(out_valid), 1);
        chk("t4_hold_index", int'(out_index), 2);
        chk("t4_hold_score", int'(out_score), 400);
        chk("t4_hold_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        #1;
        chk("t4_b2b_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("t4_b2b_busy", int'(busy), 1);
        chk("t4_b2b_valid", int'(out_valid), 0);
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        chk("t4_latency", n, 250);
        chk("t4_index", int'(out_index), 3);
        chk("t4_score", int'(out_score), 800);
        release_result();

        // 5a: reset mid-ACCUM
        cats = '0;
        set_cat(0, 50);
        set_cat(7, 800);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (100) tick();
        chk("t5_busy_before", int'(busy), 1);
        chk("t5_best_before", int'(out_score), 50);
        reset = 1'b1;
        #1;
        chk("t5r_async_busy", int'(busy), 0);
        chk("t5r_async_score", int'(out_score), 0);
        tick();
        reset = 1'b0;
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        chk("t5r_no_valid", n, 300);
        chk("t5r_index", int'(out_index), 0);
        chk("t5r_score", int'(out_score), 0);
        chk("t5r_in_ready", int'(in_ready), 1);

        // 5b: flush mid-ACCUM with a simultaneous in_valid
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (100) tick();
        chk("t5f_best_before", int'(out_score), 50);
        set_cat(4, 800);
        flush = 1'b1;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5f_busy", int'(busy), 0);
        chk("t5f_in_ready", int'(in_ready), 1);
        chk("t5f_valid", int'(out_valid), 0);
        chk("t5f_index", int'(out_index), 0);
        chk("t5f_score", int'(out_score), 0);
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        chk("t5f_no_valid", n, 300);

        // 6: small configuration, only bit 49 of category 9 set
        cats2 = '0;
        cats2[9*BPC2 + 49] = 1'b1;
        out_ready2 = 1'b0;
        in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        n = 0;
        while (!out_valid2 && n < 60) begin
            tick();
            n++;
        end
        chk("t6_latency", n, 40);
        chk("t6_index", int'(out_index2), 9);
        chk("t6_score", int'(out_score2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
